// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops len words from a FIFO onto a valid/ready stream; FIFO_BURST_READER_TIMEOUT_EN adds an empty-FIFO abort
module fifo_burst_reader #(
  parameter int WIDTH = 8,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 32,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LW-1:0]    len,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  input  logic             fifo_empty,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
);
  typedef enum logic [1:0] {
    IDLE,
    XFER,
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    DRAIN,
    ABORT
`else
    DRAIN
`endif
  } state_t;
  state_t state, nxt;
  logic [LW-1:0] remaining;
  logic pop, hs, accept, done_nxt, to_hit;
  assign hs = m_valid && m_ready;
  assign accept = (state == IDLE) && start;
  assign pop = (state == XFER) && (remaining != '0) && !fifo_empty && (!m_valid || m_ready);
  assign fifo_rd_en = pop;
  assign busy = state != IDLE;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign to_hit = (state == XFER) && (remaining != '0) && fifo_empty && (cnt == CW'(TIMEOUT - 1));
  // Count consecutive starved cycles; the sticky error clears on the next accepted command
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= (state != XFER || pop) ? '0 : (fifo_empty && remaining != '0) ? cnt + CW'(1) : cnt;
      timeout_err <= accept ? 1'b0 : to_hit ? 1'b1 : timeout_err;
    end
`else
  assign to_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif
  // Next state and the completion pulse that follows the final handshake or an abort
  always_comb begin
    nxt = state;
    done_nxt = 1'b0;
    case (state)
      IDLE: begin
        nxt = (start && len != '0) ? XFER : IDLE;
        done_nxt = start && len == '0;
      end
      XFER: nxt = to_hit ? state_t'(2'd3) : (pop && remaining == LW'(1)) ? DRAIN : XFER;
      DRAIN: begin
        nxt = (hs && m_last) ? IDLE : DRAIN;
        done_nxt = hs && m_last;
      end
      default: begin
        nxt = m_valid ? state : IDLE;
        done_nxt = !m_valid;
      end
    endcase
  end
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // Beat register: load on pop, hold while stalled, clear after an unreplaced handshake
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      remaining <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_last <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= done_nxt;
      if (accept) remaining <= (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
      else if (pop) remaining <= remaining - LW'(1);
      if (pop) begin
        m_data <= fifo_rd_data;
        m_valid <= 1'b1;
        m_last <= remaining == LW'(1);
      end else if (hs) begin
        m_valid <= 1'b0;
        m_last <= 1'b0;
      end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed bursts against a FIFO model with a stream scoreboard
module tb_fifo_burst_reader;
  logic clk = 0, rst = 1, start = 0, m_ready = 0;
  logic [4:0] len = '0;
  logic busy, done, timeout_err, fifo_rd_en, fifo_empty, m_valid, m_last;
  logic [7:0] fifo_rd_data, m_data;
  logic [7:0] mem [256];
  logic [7:0] rp = '0, wp = '0;
  int pops = 0, bad_pops = 0, checks = 0, errors = 0, hs_cnt = 0, cyc = 0;
  logic [8:0] exp_q [$];
  int hs_q [$];
  logic prev_stall = 0, prev_last = 0;
  logic [7:0] prev_data = '0;

  fifo_burst_reader #(.WIDTH(8), .MAX_LEN(16), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
    .timeout_err(timeout_err), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;
  assign fifo_empty = rp == wp;
  assign fifo_rd_data = mem[rp];

  always @(posedge clk) begin
    cyc++;
    if (fifo_rd_en) begin
      if (fifo_empty) bad_pops++;
      else begin
        rp <= rp + 8'd1;
        pops++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
      if (m_valid && m_ready) begin
        hs_cnt++;
        hs_q.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_beat", {m_last, m_data}, 9'h1ff);
        else chk("beat", {m_last, m_data}, exp_q.pop_front());
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
    end

  task automatic push(input logic [7:0] d);
    mem[wp] = d;
    wp = wp + 8'd1;
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic go(input logic [4:0] l);
    @(posedge clk);
    #1;
    start = 1;
    len = l;
    @(posedge clk);
    #1;
    start = 0;
    len = '0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    @(negedge clk);
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy"}, busy, 0);
  endtask

  function automatic logic [7:0] fill();
    return wp - rp;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int p0;
    int n;
    int pat [5] = '{1, 0, 0, 1, 1};
    logic [7:0] r;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {busy, done, timeout_err, fifo_rd_en, m_valid, m_last, m_data}, 0);
    rst = 0;
    // four back-to-back beats
    m_ready = 1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    expect_beat(8'h11, 0); expect_beat(8'h22, 0); expect_beat(8'h33, 0); expect_beat(8'h44, 1);
    hs_q.delete();
    go(4);
    wait_done(30, "t1");
    chk("t1_beats", hs_q.size(), 4);
    chk("t1_rate", hs_q[3] - hs_q[0], 3);
    chk("t1_pops", pops, 4);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    // downstream stalls
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    expect_beat(8'h01, 0); expect_beat(8'h02, 0); expect_beat(8'h03, 1);
    p0 = pops;
    go(3);
    for (int i = 0; i < 5; i++) begin
      m_ready = pat[i][0];
      @(posedge clk);
      #1;
    end
    m_ready = 1;
    wait_done(30, "t2");
    chk("t2_pops", pops - p0, 3);
    chk("t2_left", fill(), 1);
    expect_beat(8'h04, 1);
    go(1);
    wait_done(30, "t2b");
    // starved FIFO
    p0 = pops;
    go(2);
    repeat (4) @(posedge clk);
    #1;
    chk("t3_waiting", {busy, m_valid}, 2'b10);
    expect_beat(8'hA5, 0);
    push(8'hA5);
    repeat (4) @(posedge clk);
    #1;
    expect_beat(8'h5A, 1);
    push(8'h5A);
    wait_done(30, "t3");
    chk("t3_pops", pops - p0, 2);
    // zero length
    p0 = pops;
    go(0);
    @(negedge clk);
    chk("t4_zero", {done, busy, m_valid, fifo_rd_en}, 4'b1000);
    @(negedge clk);
    chk("t4_zero_after", {done, pops - p0}, 0);
    // length clamps to 16
    p0 = pops;
    for (int i = 0; i < 16; i++) begin
      push(8'h80 + 8'(i));
      expect_beat(8'h80 + 8'(i), i == 15);
    end
    push(8'hEE);
    go(17);
    wait_done(100, "t5");
    chk("t5_pops", pops - p0, 16);
    chk("t5_left", fill(), 1);
    // reset mid-burst
    push(8'h61); push(8'h62); push(8'h63);
    expect_beat(8'hEE, 0); expect_beat(8'h61, 0); expect_beat(8'h62, 0); expect_beat(8'h63, 1);
    p0 = hs_cnt;
    go(4);
    n = 0;
    while (hs_cnt < p0 + 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("t6_two_beats", hs_cnt >= p0 + 2, 1);
    #2;
    rst = 1;
    #1;
    chk("t6_rst_outs", {busy, done, timeout_err, fifo_rd_en, m_valid, m_last, m_data}, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 0;
    push(8'h71); push(8'h72);
    r = rp;
    expect_beat(mem[r], 0);
    expect_beat(mem[r + 8'd1], 1);
    p0 = pops;
    go(2);
    wait_done(30, "t6");
    chk("t6_pops", pops - p0, 2);
    while (fill() != 0) begin
      expect_beat(mem[rp], fill() == 1);
      go(1);
      wait_done(30, "flush");
    end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    // FIFO runs dry mid-burst
    p0 = pops;
    push(8'h99);
    expect_beat(8'h99, 0);
    go(4);
    repeat (10) @(posedge clk);
    #1;
    chk("t7_pending", {busy, timeout_err}, 2'b10);
    wait_done(100, "t7");
    chk("t7_err", timeout_err, 1);
    chk("t7_pops", pops - p0, 1);
    go(0);
    @(negedge clk);
    chk("t7_err_clear", {done, timeout_err}, 2'b10);
`endif
    chk("no_empty_pops", bad_pops, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
